// File: rtl/scs8hd_inv_pipe_bank_pkg.sv
// Shared definitions for the inverting pipeline bank: stage-mode encoding
// and parameter legality helpers.
package scs8hd_inv_pipe_bank_pkg;

    typedef logic [1:0] mode_t;

    // Stage-enable modes driven from the top-level decode into every stage.
    localparam mode_t MODE_HOLD    = 2'd0;
    localparam mode_t MODE_CAPTURE = 2'd1;
    localparam mode_t MODE_SHIFT   = 2'd2;

    localparam int WIDTH_MIN = 1;
    localparam int WIDTH_MAX = 32;
    localparam int DEPTH_MIN = 1;
    localparam int DEPTH_MAX = 4;

    function automatic bit width_legal(input int w);
        return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
    endfunction

    function automatic bit depth_legal(input int d);
        return (d >= DEPTH_MIN) && (d <= DEPTH_MAX);
    endfunction

endpackage

// File: rtl/scs8hd_inv_pipe_stage.sv
// One WIDTH-bit pipeline stage: parallel capture, serial scan shift
// (bit 0 in, bit WIDTH-1 out) and hold, with asynchronous clear.
module scs8hd_inv_pipe_stage
    import scs8hd_inv_pipe_bank_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  mode_t            mode,
    input  logic [WIDTH-1:0] cap_d,
    input  logic             shift_in,
    output logic [WIDTH-1:0] q,
    output logic             shift_out
);

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] shift_next_s;

    // A one-bit stage has no internal neighbour; the scan bit replaces it.
    if (WIDTH == 1) begin : g_shift_w1
        assign shift_next_s = shift_in;
    end else begin : g_shift_wn
        assign shift_next_s = {q_r[WIDTH-2:0], shift_in};
    end

    // Stage register: clear on reset, otherwise hold, capture or shift by mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_r <= {WIDTH{1'b0}};
        end else begin
            case (mode)
                MODE_HOLD:    q_r <= q_r;
                MODE_CAPTURE: q_r <= cap_d;
                MODE_SHIFT:   q_r <= shift_next_s;
                default:      q_r <= {WIDTH{1'bx}};
            endcase
        end
    end

    assign q         = q_r;
    assign shift_out = q_r[WIDTH-1];

endmodule

// File: rtl/scs8hd_inv_pipe_bank.sv
// WIDTH-bit inverting retiming pipeline of DEPTH stages with a full scan
// chain through every stored bit. Mask inversion applies only on capture.
module scs8hd_inv_pipe_bank
    import scs8hd_inv_pipe_bank_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter int               DEPTH    = 2,
    parameter logic [WIDTH-1:0] INV_MASK = {WIDTH{1'b1}}
) (
`ifdef SC_USE_PG_PIN
    input  logic             vpwr,
    input  logic             vgnd,
    input  logic             vpb,
    input  logic             vnb,
`endif
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] A,
    input  logic             DE,
    input  logic             SCE,
    input  logic             SCD,
    output logic [WIDTH-1:0] Y,
    output logic             SCO
);

    // Out-of-range parameters elaborate a module that does not exist.
    if (!(width_legal(WIDTH) && depth_legal(DEPTH))) begin : g_bad_params
        illegal_scs8hd_inv_pipe_bank_parameters u_bad ();
    end

    mode_t            mode_s;
    logic [WIDTH-1:0] stage_q_s  [DEPTH];
    logic [DEPTH-1:0] stage_so_s;

    // Mode decode: scan enable wins over data enable; unknown controls poison.
    always_comb begin
        mode_s = MODE_HOLD;
        case ({SCE, DE})
            2'b00:        mode_s = MODE_HOLD;
            2'b01:        mode_s = MODE_CAPTURE;
            2'b10, 2'b11: mode_s = MODE_SHIFT;
            default:      mode_s = 2'bxx;
        endcase
    end

    // Stage 0 captures the masked input and takes SCD; later stages chain on.
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic [WIDTH-1:0] cap_d_s;
        logic             shift_in_s;

        if (k == 0) begin : g_head
            assign cap_d_s    = A ^ INV_MASK;
            assign shift_in_s = SCD;
        end else begin : g_tail
            assign cap_d_s    = stage_q_s[k-1];
            assign shift_in_s = stage_so_s[k-1];
        end

        scs8hd_inv_pipe_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk       (CLK),
            .rst       (RESET),
            .mode      (mode_s),
            .cap_d     (cap_d_s),
            .shift_in  (shift_in_s),
            .q         (stage_q_s[k]),
            .shift_out (stage_so_s[k])
        );
    end

`ifdef SC_USE_PG_PIN
    for (genvar i = 0; i < WIDTH; i++) begin : g_pg_y
        scs8hd_pg_U_VPWR_VGND u_pg_y (Y[i], stage_q_s[DEPTH-1][i], vpwr, vgnd);
    end
    scs8hd_pg_U_VPWR_VGND u_pg_sco (SCO, stage_so_s[DEPTH-1], vpwr, vgnd);
`else
    assign Y   = stage_q_s[DEPTH-1];
    assign SCO = stage_so_s[DEPTH-1];
`endif

`ifdef SCS8HD_TIMING
    reg notifier;
    specify
        (CLK *> Y)   = (0:0:0, 0:0:0);
        (CLK => SCO) = (0:0:0, 0:0:0);
        $setuphold(posedge CLK, A,   0:0:0, 0:0:0, notifier);
        $setuphold(posedge CLK, DE,  0:0:0, 0:0:0, notifier);
        $setuphold(posedge CLK, SCE, 0:0:0, 0:0:0, notifier);
        $setuphold(posedge CLK, SCD, 0:0:0, 0:0:0, notifier);
    endspecify
`endif

endmodule

// File: tb/tb_scs8hd_inv_pipe_bank.sv
// Self-checking bench: six parameterisations share one stimulus stream and
// are each compared against a flat-chain reference model.
module tb_scs8hd_inv_pipe_bank;

    localparam int N = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a;
    logic        de, sce, scd;

    logic [7:0]   y0, y1;
    logic [0:0]   y2, y3;
    logic [31:0]  y4, y5;
    logic [N-1:0] sco;
    logic [31:0]  y_all [N];

    int          W [N] = '{8, 8, 1, 1, 32, 32};
    int          D [N] = '{2, 2, 1, 4, 3, 4};
    logic [31:0] M [N] = '{32'h0000_00FF, 32'h0000_000F, 32'h0000_0001,
                           32'h0000_0001, 32'h5A5A_0FF0, 32'hF0F0_A5C3};

    // Whole scan chain per instance: bit 0 = stage[0][0], top = stage[D-1][W-1].
    logic [127:0] chain_m [N];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    scs8hd_inv_pipe_bank #(.WIDTH(8), .DEPTH(2), .INV_MASK(8'hFF)) dut0 (
        .CLK(clk), .RESET(rst), .A(a[7:0]), .DE(de), .SCE(sce), .SCD(scd), .Y(y0), .SCO(sco[0]));
    scs8hd_inv_pipe_bank #(.WIDTH(8), .DEPTH(2), .INV_MASK(8'h0F)) dut1 (
        .CLK(clk), .RESET(rst), .A(a[7:0]), .DE(de), .SCE(sce), .SCD(scd), .Y(y1), .SCO(sco[1]));
    scs8hd_inv_pipe_bank #(.WIDTH(1), .DEPTH(1), .INV_MASK(1'b1)) dut2 (
        .CLK(clk), .RESET(rst), .A(a[0:0]), .DE(de), .SCE(sce), .SCD(scd), .Y(y2), .SCO(sco[2]));
    scs8hd_inv_pipe_bank #(.WIDTH(1), .DEPTH(4), .INV_MASK(1'b1)) dut3 (
        .CLK(clk), .RESET(rst), .A(a[0:0]), .DE(de), .SCE(sce), .SCD(scd), .Y(y3), .SCO(sco[3]));
    scs8hd_inv_pipe_bank #(.WIDTH(32), .DEPTH(3), .INV_MASK(32'h5A5A_0FF0)) dut4 (
        .CLK(clk), .RESET(rst), .A(a), .DE(de), .SCE(sce), .SCD(scd), .Y(y4), .SCO(sco[4]));
    scs8hd_inv_pipe_bank #(.WIDTH(32), .DEPTH(4), .INV_MASK(32'hF0F0_A5C3)) dut5 (
        .CLK(clk), .RESET(rst), .A(a), .DE(de), .SCE(sce), .SCD(scd), .Y(y5), .SCO(sco[5]));

    assign y_all[0] = {24'd0, y0};
    assign y_all[1] = {24'd0, y1};
    assign y_all[2] = {31'd0, y2};
    assign y_all[3] = {31'd0, y3};
    assign y_all[4] = y4;
    assign y_all[5] = y5;

    function automatic logic [127:0] ones(input int n);
        logic [127:0] m;
        m = '0;
        for (int j = 0; j < n; j++) m[j] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] model_y(input int i);
        logic [127:0] t;
        t = (chain_m[i] >> (W[i] * (D[i] - 1))) & ones(W[i]);
        return t[31:0];
    endfunction

    function automatic logic model_sco(input int i);
        return chain_m[i][W[i]*D[i]-1];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < N; i++) begin
            if (sce)
                chain_m[i] = ((chain_m[i] << 1) | {127'd0, scd}) & ones(W[i] * D[i]);
            else if (de)
                chain_m[i] = ((chain_m[i] << W[i]) | ({96'd0, a ^ M[i]} & ones(W[i])))
                             & ones(W[i] * D[i]);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("%s_y%0d", tag, i), y_all[i], model_y(i));
            chk($sformatf("%s_sco%0d", tag, i), {31'd0, sco[i]}, {31'd0, model_sco(i)});
        end
    endtask

    task automatic tick(input logic [31:0] a_v, input logic de_v, input logic sce_v, input logic scd_v);
        a   = a_v;
        de  = de_v;
        sce = sce_v;
        scd = scd_v;
        @(posedge clk);
        model_edge();
        #1;
        check_all("mdl");
    endtask

    // Asserted just after an edge, checked before any further edge, released on negedge.
    task automatic async_reset();
        rst = 1'b1;
        #1;
        for (int i = 0; i < N; i++) chain_m[i] = '0;
        check_all("rst");
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic [31:0] a;
        logic        de;
        logic        sce;
        logic        scd;
        logic [7:0]  exp_y;
        logic        exp_sco;
    } vec_t;

    vec_t         tbl [8];
    logic [31:0]  a0;
    logic [15:0]  pat;
    logic [15:0]  got;
    int           lat [N];

    initial begin
        tbl[0] = '{32'h3C, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
        tbl[1] = '{32'h00, 1'b1, 1'b0, 1'b0, 8'hC3, 1'b1};
        tbl[2] = '{32'h12, 1'b0, 1'b0, 1'b0, 8'hC3, 1'b1};
        tbl[3] = '{32'h55, 1'b1, 1'b0, 1'b0, 8'hFF, 1'b1};
        tbl[4] = '{32'h00, 1'b1, 1'b0, 1'b0, 8'hAA, 1'b1};
        tbl[5] = '{32'hFF, 1'b1, 1'b1, 1'b1, 8'h55, 1'b0};
        tbl[6] = '{32'h00, 1'b0, 1'b1, 1'b0, 8'hAB, 1'b1};
        tbl[7] = '{32'hF0, 1'b1, 1'b0, 1'b0, 8'hFE, 1'b1};

        rst = 1'b1; a = 32'd0; de = 1'b1; sce = 1'b0; scd = 1'b0;
        for (int i = 0; i < N; i++) chain_m[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all("por");
        @(negedge clk);
        rst = 1'b0;

        // Capture/hold/shift-priority vectors on the 8x2 full-inversion instance.
        for (int r = 0; r < 8; r++) begin
            tick(tbl[r].a, tbl[r].de, tbl[r].sce, tbl[r].scd);
            chk($sformatf("tbl%0d_y", r), {24'd0, y0}, {24'd0, tbl[r].exp_y});
            chk($sformatf("tbl%0d_sco", r), {31'd0, sco[0]}, {31'd0, tbl[r].exp_sco});
        end

        // Async clear while the 8x2 stages hold A5.
        tick(32'h5A, 1'b1, 1'b0, 1'b0);
        tick(32'h5A, 1'b1, 1'b0, 1'b0);
        chk("a5_loaded", {24'd0, y0}, 32'h0000_00A5);
        async_reset();
        chk("rst_mid_y", {24'd0, y0}, 32'd0);
        chk("rst_mid_sco", {31'd0, sco[0]}, 32'd0);

        // Stall: nibble mask, then five disabled edges with different input.
        tick(32'hAA, 1'b1, 1'b0, 1'b0);
        tick(32'hAA, 1'b1, 1'b0, 1'b0);
        chk("stall_load", {24'd0, y1}, 32'h0000_00A5);
        for (int j = 0; j < 5; j++) begin
            tick(32'h55, 1'b0, 1'b0, 1'b0);
            chk($sformatf("stall_hold%0d", j), {24'd0, y1}, 32'h0000_00A5);
        end

        // Scan load of BEEF into the 8x2 chain, then unload through SCO.
        async_reset();
        pat = 16'hBEEF;
        for (int j = 0; j < 16; j++) tick($urandom, 1'($urandom_range(0, 1)), 1'b1, pat[15-j]);
        chk("scan_load_y", {24'd0, y0}, 32'h0000_00BE);
        got = 16'd0;
        for (int j = 0; j < 16; j++) begin
            got[15-j] = sco[0];
            tick($urandom, 1'b0, 1'b1, 1'b0);
        end
        chk("scan_unload", {16'd0, got}, {16'd0, pat});

        // Latency in enabled edges, with a disabled gap after the first capture.
        async_reset();
        a0 = 32'h1357_9BDE;
        tick(a0, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            if (k > 1) tick($urandom, 1'b1, 1'b0, 1'b0);
            else       tick($urandom, 1'b0, 1'b0, 1'b0);
            for (int i = 0; i < N; i++) begin
                if (k == D[i])
                    chk($sformatf("lat_hit%0d", i), y_all[i], (a0 ^ M[i]) & ones(W[i]) >> 0);
                else if (k < D[i])
                    chk($sformatf("lat_early%0d", i), y_all[i], 32'd0);
            end
        end

        // Scan length: a single 1 reaches SCO after exactly WIDTH*DEPTH shifts.
        async_reset();
        for (int i = 0; i < N; i++) lat[i] = 0;
        for (int e = 1; e <= 130; e++) begin
            tick($urandom, 1'b1, 1'b1, (e == 1) ? 1'b1 : 1'b0);
            for (int i = 0; i < N; i++)
                if (lat[i] == 0 && sco[i] === 1'b1) lat[i] = e;
        end
        for (int i = 0; i < N; i++)
            chk($sformatf("scan_len%0d", i), lat[i], W[i] * D[i]);

        // Random traffic with occasional asynchronous reset.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 49) == 0)
                async_reset();
            else
                tick($urandom, 1'($urandom_range(0, 3) != 0),
                     1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
